// File: rtl/main_ram_dma_pkg.sv
// Shared types and default widths for the main RAM block-copy/fill DMA engine.
package main_ram_dma_pkg;

    localparam int ADDR_W_DEFAULT = 15;
    localparam int LEN_W_DEFAULT  = 16;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        LATCH,
        WR
    } state_e;

endpackage

// File: rtl/main_ram_dma.sv
// Word-granular COPY/FILL bus initiator for the main RAM port, behind a req/gnt arbiter.
// Bus outputs are decoded from registered state so a stalled grant only affects bus_write.
module main_ram_dma
    import main_ram_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len,
    input  logic [DATA_W-1:0]   fill_data,
    output logic                busy,
    output logic                done,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wrdata,
    output logic [DATA_W/8-1:0] bus_wrbytesel,
    output logic                bus_write,
    input  logic [DATA_W-1:0]   bus_rddata
);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;

    // NOTE: every register updates with <= so all flops see pre-edge values,
    // independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // NOTE: each output is given a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        fill_d     = fill_q;
        data_d     = data_q;
        done_d     = 1'b0;
        bus_req    = 1'b0;
        bus_addr   = '0;
        bus_wrdata = '0;
        bus_write  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = len;
                    fill_d = fill_data;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = (mode == MODE_FILL) ? WR : RD;
                    end
                end
            end
            RD: begin
                bus_req  = 1'b1;
                bus_addr = src_q;
                if (bus_gnt) state_d = LATCH;
            end
            LATCH: begin
                data_d  = bus_rddata;
                state_d = WR;
            end
            WR: begin
                bus_req    = 1'b1;
                bus_addr   = dst_q;
                bus_wrdata = (mode_q == MODE_FILL) ? fill_q : data_q;
                bus_write  = bus_gnt;
                if (bus_gnt) begin
                    dst_d = dst_q + ADDR_W'(1);
                    if (mode_q == MODE_COPY) src_d = src_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = (mode_q == MODE_FILL) ? WR : RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign bus_wrbytesel = '1;

endmodule

// File: doc/main_ram_dma.md
Name: main_ram_dma

Overview:
- Bus initiator for the main RAM word port (word address, 32-bit data, 4-bit byte select, write strobe, 1-cycle read latency, write-first).
- Performs word-granular block COPY (RAM→RAM) and FILL (constant→RAM) jobs under a start/busy/done handshake.
- Requests the RAM port through a req/gnt pair, so it sits behind the RAM arbiter alongside the CPU data port.

Parameters:
- ADDR_W, 15, word address width; matches a 128 KB main RAM.
- LEN_W, 16, length field width in words; 0..2^15 meaningful.
- DATA_W, 32, bus data width; byte select width is DATA_W/8.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job launch; sampled only in IDLE
- mode  in  1  0=COPY, 1=FILL; sampled with start
- src_addr  in  ADDR_W  first source word address (COPY only)
- dst_addr  in  ADDR_W  first destination word address
- len  in  LEN_W  job length in words
- fill_data  in  DATA_W  pattern for FILL; sampled with start
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- bus_req  out  1  RAM port request
- bus_gnt  in  1  RAM port grant, same-cycle; a bus op happens only in a cycle with req&&gnt
- bus_addr  out  ADDR_W  RAM word address
- bus_wrdata  out  DATA_W  RAM write data
- bus_wrbytesel  out  DATA_W/8  byte enables; constant all-ones
- bus_write  out  1  write strobe; equals (state==WR && bus_gnt)
- bus_rddata  in  DATA_W  RAM read data, valid the cycle after a granted read

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, bus_req=0, bus_write=0, bus_addr=0, bus_wrdata=0. Internal counters and data register are cleared. Reset mid-job aborts it with no done pulse. A write already strobed stays committed.
- States: IDLE, RD, LATCH, WR.
- IDLE:
  - start=1 latches mode, src, dst, len and fill_data.
  - len==0: go straight to done=1 next cycle, with no bus traffic.
  - Otherwise go to RD (COPY) or WR (FILL).
- RD: bus_req=1, bus_addr=src_ptr, bus_write=0. On gnt, advance to LATCH; else hold.
- LATCH: bus_req=0. data_q<=bus_rddata. Go to WR.
- WR: bus_req=1, bus_addr=dst_ptr, bus_wrdata = data_q (COPY) or fill_q (FILL). On gnt:
  - Increment dst_ptr, increment src_ptr (COPY), decrement remaining.
  - If remaining was 1: go to IDLE and pulse done.
  - Else go to RD (COPY) or stay in WR (FILL).
- Pointers wrap modulo 2^ADDR_W.
- Copy runs strictly ascending, one word at a time. Overlap with dst>src is defined as ascending word-by-word (smears); no reordering.
- busy=1 in every non-IDLE state. done=1 exactly one cycle, the first IDLE cycle after the last granted write, with busy=0.
- start while busy is ignored.
- Throughput with gnt held high:
  - FILL: N writes at cycles 1..N, done at cycle N+1 (start at cycle 0).
  - COPY: 3 cycles/word, last write at cycle 3N, done at cycle 3N+1.
- gnt low stalls RD or WR without changing any output other than bus_write. A LATCH capture is never stalled.

Decomposition:
- Shared package main_ram_dma_pkg:
  - state enum {IDLE, RD, LATCH, WR}
  - MODE_COPY=0, MODE_FILL=1
  - default ADDR_W/LEN_W/DATA_W constants
- No sub-module. Pointer and remaining counters are simple registers in the top.

Test Plan:
- FILL dst=0x0100, len=4, fill=0xDEADBEEF, gnt=1 → writes to 0x0100..0x0103 at cycles 1..4, wrbytesel=4'hF; done at cycle 5; RAM readback matches.
- COPY src=0x0000 (preloaded 0x11111111..0x44444444), dst=0x2000, len=4, gnt=1 → last write at cycle 12, done at cycle 13; 0x2000..0x2003 hold 0x11111111..0x44444444.
- COPY len=3 with gnt toggling 1,0,0,1 pseudo-randomly → same final data. bus_write is never high while gnt=0. done is exactly one pulse.
- FILL dst=0x7FFE, len=4 → writes 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- len=0 start → done next cycle, bus_req never asserted. A second start while busy on a len=8 job → ignored; only the first job's writes occur.
- Assert rst after 2 of 6 FILL writes → all outputs 0 immediately. No done pulse. Only 2 words are modified.
